initials_entry: RTL

- Player-facing writer for the high-score name interface.
- Lets the player dial in five 6-bit letter codes using up/down/next/back buttons.
- Drives the letter1..letter5 bus and pulses doneSave to the game controller, which latches the name into the high-score record.
- Sits between the debounced button inputs and the game state block. Active only while the game requests name entry.

---
 rtl/initials_entry.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/initials_entry.sv
// initials_entry: lets the player dial in a five-letter high-score name.
//
// The player edits five 6-bit letter codes (0 = blank, 1..26 = A..Z) with
// the debounced up/down/next/back buttons. Holding up or down auto-repeats.
// A Next press on the last slot commits the name with a one-cycle doneSave
// pulse, after which the block waits for every button and start to drop
// before it returns to idle.
//
// Ports:
//   clk       in   system clock
//   resetn    in   synchronous reset, active HIGH despite the name
//   start     in   level from the game controller requesting name entry
//   btnUp     in   debounced level, steps the current letter up
//   btnDown   in   debounced level, steps the current letter down
//   btnNext   in   debounced level, cursor right / commit from last slot
//   btnBack   in   debounced level, cursor left
//   letter1-5 out  current letter codes, letter1 is leftmost
//   cursor    out  slot under edit, 0..4
//   active    out  high while editing
//   doneSave  out  single-cycle commit pulse

module initials_entry #(
    parameter int unsigned MAX_CODE     = 26,
    parameter int unsigned DEFAULT_CODE = 1,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnNext,
    input  logic       btnBack,
    output logic [5:0] letter1,
    output logic [5:0] letter2,
    output logic [5:0] letter3,
    output logic [5:0] letter4,
    output logic [5:0] letter5,
    output logic [2:0] cursor,
    output logic       active,
    output logic       doneSave
);

    localparam logic [5:0] MAX_C     = 6'(MAX_CODE);
    localparam logic [5:0] DEFAULT_C = 6'(DEFAULT_CODE);
    localparam logic [2:0] LAST_SLOT = 3'd4;

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

    typedef enum logic [1:0] {
        StIdle,
        StEdit,
        StSave,
        StRelease
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [5:0]       r_letters     [5];
    logic [5:0]       w_letters_nxt [5];
    logic [2:0]       r_cursor;
    logic [2:0]       w_cursor_nxt;

    // Previous button levels for edge detection.
    logic             r_up_prev;
    logic             r_dn_prev;
    logic             r_nx_prev;
    logic             r_bk_prev;

    // Auto-repeat: r_rpt_cnt counts cycles since the press edge (or since
    // the last tick); zero means idle. r_rpt_rep marks that the first
    // (long) delay has already elapsed.
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic             r_rpt_rep;
    logic             w_rpt_rep_nxt;
    logic             r_rpt_dir;
    logic             w_rpt_dir_nxt;

    logic             w_up_ev;
    logic             w_dn_ev;
    logic             w_nx_ev;
    logic             w_bk_ev;
    logic             w_one_dir;
    logic             w_dir_ev;
    logic             w_holding;
    logic             w_tick;
    logic             w_up_tick;
    logic             w_dn_tick;
    logic [5:0]       w_slot;
    logic [5:0]       w_slot_up;
    logic [5:0]       w_slot_dn;

    assign w_up_ev = btnUp & ~r_up_prev;
    assign w_dn_ev = btnDown & ~r_dn_prev;
    assign w_nx_ev = btnNext & ~r_nx_prev;
    assign w_bk_ev = btnBack & ~r_bk_prev;

    // Exactly one of up/down held; btnUp then gives the direction.
    assign w_one_dir = btnUp ^ btnDown;
    assign w_dir_ev  = btnUp ? w_up_ev : w_dn_ev;

    // A repeat run continues only while the same single direction stays held.
    assign w_holding = (r_state == StEdit) && w_one_dir && (r_rpt_cnt != '0) &&
                       (r_rpt_dir == btnUp) && !w_dir_ev;
    assign w_tick    = w_holding &&
                       ((!r_rpt_rep && (r_rpt_cnt == DELAY_C)) ||
                        (r_rpt_rep && (r_rpt_cnt == RATE_C)));
    assign w_up_tick = w_tick && r_rpt_dir;
    assign w_dn_tick = w_tick && !r_rpt_dir;

    // Auto-repeat counter next state. Only a real press edge starts a run,
    // so a button already held when editing begins never repeats.
    always_comb begin
        w_rpt_cnt_nxt = '0;
        w_rpt_rep_nxt = 1'b0;
        w_rpt_dir_nxt = r_rpt_dir;
        if ((r_state == StEdit) && w_one_dir && w_dir_ev) begin
            w_rpt_cnt_nxt = CNT_W'(1);
            w_rpt_dir_nxt = btnUp;
        end else if (w_holding) begin
            if (w_tick) begin
                w_rpt_cnt_nxt = CNT_W'(1);
                w_rpt_rep_nxt = 1'b1;
            end else begin
                w_rpt_cnt_nxt = r_rpt_cnt + CNT_W'(1);
                w_rpt_rep_nxt = r_rpt_rep;
            end
        end
    end

    // Letter under the cursor and its wrapped neighbours.
    always_comb begin
        w_slot = '0;
        for (int i = 0; i < 5; i++) begin
            if (r_cursor == 3'(i)) begin
                w_slot = r_letters[i];
            end
        end
        w_slot_up = (w_slot == MAX_C) ? 6'd0 : w_slot + 6'd1;
        w_slot_dn = (w_slot == 6'd0) ? MAX_C : w_slot - 6'd1;
    end

    // FSM next state plus letter/cursor datapath.
    always_comb begin
        w_state_nxt   = r_state;
        w_letters_nxt = r_letters;
        w_cursor_nxt  = r_cursor;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StEdit;
                    w_cursor_nxt = 3'd0;
                    for (int i = 0; i < 5; i++) begin
                        w_letters_nxt[i] = DEFAULT_C;
                    end
                end
            end

            StEdit: begin
                // Losing start abandons the edit; any button activity that
                // cycle is ignored.
                if (!start) begin
                    w_state_nxt = StIdle;
                end else if (w_nx_ev && w_bk_ev) begin
                    // Contradictory cursor request: ignore both.
                end else if (w_nx_ev) begin
                    if (r_cursor == LAST_SLOT) begin
                        w_state_nxt = StSave;
                    end else begin
                        w_cursor_nxt = r_cursor + 3'd1;
                    end
                end else if (w_bk_ev) begin
                    if (r_cursor != 3'd0) begin
                        w_cursor_nxt = r_cursor - 3'd1;
                    end
                end else if (btnUp && btnDown) begin
                    // Both directions held: no step.
                end else if (w_up_ev || w_up_tick) begin
                    for (int i = 0; i < 5; i++) begin
                        if (r_cursor == 3'(i)) begin
                            w_letters_nxt[i] = w_slot_up;
                        end
                    end
                end else if (w_dn_ev || w_dn_tick) begin
                    for (int i = 0; i < 5; i++) begin
                        if (r_cursor == 3'(i)) begin
                            w_letters_nxt[i] = w_slot_dn;
                        end
                    end
                end
            end

            StSave: begin
                w_state_nxt = StRelease;
            end

            StRelease: begin
                // Hold off until the controller drops start and every button
                // is released, so a held Next cannot re-enter editing.
                if (!start && !btnUp && !btnDown && !btnNext && !btnBack) begin
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state   <= StIdle;
            r_cursor  <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                r_letters[i] <= DEFAULT_C;
            end
            r_up_prev <= 1'b0;
            r_dn_prev <= 1'b0;
            r_nx_prev <= 1'b0;
            r_bk_prev <= 1'b0;
            r_rpt_cnt <= '0;
            r_rpt_rep <= 1'b0;
            r_rpt_dir <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cursor  <= w_cursor_nxt;
            r_letters <= w_letters_nxt;
            r_up_prev <= btnUp;
            r_dn_prev <= btnDown;
            r_nx_prev <= btnNext;
            r_bk_prev <= btnBack;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_rpt_rep <= w_rpt_rep_nxt;
            r_rpt_dir <= w_rpt_dir_nxt;
        end
    end

    assign letter1  = r_letters[0];
    assign letter2  = r_letters[1];
    assign letter3  = r_letters[2];
    assign letter4  = r_letters[3];
    assign letter5  = r_letters[4];
    assign cursor   = r_cursor;
    assign active   = (r_state == StEdit);
    assign doneSave = (r_state == StSave);

endmodule
